// File: rtl/bp_io_cmd_rr_arbiter.sv
// Round-robin arbiter sharing the chip I/O-command ingress between the NBF loader (req0)
// and the host/debug master (req1), routing in-order responses back through a source-tag FIFO.
module bp_io_cmd_rr_arbiter #(
    parameter int msg_width_p       = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic [msg_width_p-1:0] req0_cmd_i,
    input  logic                   req0_cmd_v_i,
    output logic                   req0_cmd_yumi_o,
    output logic [msg_width_p-1:0] req0_resp_o,
    output logic                   req0_resp_v_o,
    input  logic                   req0_resp_ready_i,

    input  logic [msg_width_p-1:0] req1_cmd_i,
    input  logic                   req1_cmd_v_i,
    output logic                   req1_cmd_yumi_o,
    output logic [msg_width_p-1:0] req1_resp_o,
    output logic                   req1_resp_v_o,
    input  logic                   req1_resp_ready_i,

    output logic [msg_width_p-1:0] io_cmd_o,
    output logic                   io_cmd_v_o,
    input  logic                   io_cmd_yumi_i,
    input  logic [msg_width_p-1:0] io_resp_i,
    input  logic                   io_resp_v_i,
    output logic                   io_resp_ready_o
);

    localparam int ptr_w = $clog2(max_outstanding_p);
    localparam int cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_outstanding_p);

    typedef enum logic {
        e_idle,
        e_lock
    } state_e;

    state_e                 state_q;
    logic                   lock_grant_q;
    logic                   prio_q;
    logic [ptr_w-1:0]       wr_ptr_q;
    logic [ptr_w-1:0]       rd_ptr_q;
    logic [cnt_w-1:0]       cnt_q;
    logic [max_outstanding_p-1:0] tag_mem;

    logic grant;
    logic any_v;
    logic fifo_full;
    logic fifo_empty;
    logic head;
    logic head_ready;
    logic cmd_hs;
    logic resp_hs;

    assign any_v      = req0_cmd_v_i | req1_cmd_v_i;
    assign fifo_full  = (cnt_q == cnt_max);
    assign fifo_empty = (cnt_q == '0);
    assign head       = tag_mem[rd_ptr_q];

    // Locked grant wins; otherwise favour the pointer's requester and fall back to the other.
    always_comb begin
        grant = 1'b0;
        if (state_q == e_lock) begin
            grant = lock_grant_q;
        end else if (prio_q) begin
            grant = req1_cmd_v_i ? 1'b1 : 1'b0;
        end else begin
            grant = req0_cmd_v_i ? 1'b0 : 1'b1;
        end
    end

    // Handshake outputs are forced low while reset is held, so they never glitch high
    // from leftover requester valids during an asynchronous reset.
    assign io_cmd_v_o      = reset_i & ((state_q == e_lock) | (any_v & ~fifo_full));
    assign io_cmd_o        = grant ? req1_cmd_i : req0_cmd_i;
    assign cmd_hs          = io_cmd_v_o & io_cmd_yumi_i;
    assign req0_cmd_yumi_o = cmd_hs & ~grant;
    assign req1_cmd_yumi_o = cmd_hs &  grant;

    assign head_ready      = head ? req1_resp_ready_i : req0_resp_ready_i;
    assign io_resp_ready_o = reset_i & ~fifo_empty & head_ready;
    assign resp_hs         = io_resp_v_i & io_resp_ready_o;
    assign req0_resp_o     = io_resp_i;
    assign req1_resp_o     = io_resp_i;
    assign req0_resp_v_o   = reset_i & io_resp_v_i & ~fifo_empty & ~head;
    assign req1_resp_v_o   = reset_i & io_resp_v_i & ~fifo_empty &  head;

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= e_idle;
            lock_grant_q <= 1'b0;
            prio_q       <= 1'b0;
        end else begin
            unique case (state_q)
                e_idle: begin
                    if (io_cmd_v_o && !io_cmd_yumi_i) begin
                        state_q      <= e_lock;
                        lock_grant_q <= grant;
                    end
                end
                e_lock: begin
                    if (io_cmd_yumi_i) begin
                        state_q <= e_idle;
                    end
                end
                default: state_q <= e_idle;
            endcase
            if (cmd_hs) begin
                prio_q <= ~grant;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (cmd_hs) begin
                wr_ptr_q <= wr_ptr_q + ptr_w'(1);
            end
            if (resp_hs) begin
                rd_ptr_q <= rd_ptr_q + ptr_w'(1);
            end
            unique case ({cmd_hs, resp_hs})
                2'b10:   cnt_q <= cnt_q + cnt_w'(1);
                2'b01:   cnt_q <= cnt_q - cnt_w'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: tag storage has no reset; entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (cmd_hs) begin
            tag_mem[wr_ptr_q] <= grant;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_i) begin
            if (state_q == e_lock && !lock_grant_q) assert (req0_cmd_v_i);
            if (state_q == e_lock &&  lock_grant_q) assert (req1_cmd_v_i);
            assert (!(cmd_hs && fifo_full));
            assert (!(resp_hs && fifo_empty));
        end
    end
`endif

endmodule

// File: tb/tb_bp_io_cmd_rr_arbiter.sv
// Directed bench for bp_io_cmd_rr_arbiter with command/response scoreboards checked by a negedge monitor.
module tb_bp_io_cmd_rr_arbiter;

    localparam int W = 64;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] req0_cmd_i, req1_cmd_i, req0_resp_o, req1_resp_o;
    logic         req0_cmd_v_i, req0_cmd_yumi_o, req0_resp_v_o, req0_resp_ready_i;
    logic         req1_cmd_v_i, req1_cmd_yumi_o, req1_resp_v_o, req1_resp_ready_i;
    logic [W-1:0] io_cmd_o, io_resp_i;
    logic         io_cmd_v_o, io_cmd_yumi_i, io_resp_v_i, io_resp_ready_o;

    bp_io_cmd_rr_arbiter #(.msg_width_p(W), .max_outstanding_p(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req0_cmd_i(req0_cmd_i), .req0_cmd_v_i(req0_cmd_v_i), .req0_cmd_yumi_o(req0_cmd_yumi_o),
        .req0_resp_o(req0_resp_o), .req0_resp_v_o(req0_resp_v_o), .req0_resp_ready_i(req0_resp_ready_i),
        .req1_cmd_i(req1_cmd_i), .req1_cmd_v_i(req1_cmd_v_i), .req1_cmd_yumi_o(req1_cmd_yumi_o),
        .req1_resp_o(req1_resp_o), .req1_resp_v_o(req1_resp_v_o), .req1_resp_ready_i(req1_resp_ready_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_yumi_i(io_cmd_yumi_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_ready_o(io_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t cmd_q[$];
    exp_t resp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_cmd_hs = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req0_cmd_v_i = 0; req1_cmd_v_i = 0; req0_cmd_i = '0; req1_cmd_i = '0;
        io_cmd_yumi_i = 0; io_resp_v_i = 0; io_resp_i = '0;
        req0_resp_ready_i = 0; req1_resp_ready_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 0;
        repeat (2) step();
        reset_i = 1;
    endtask

    task automatic exp_cmd(input logic id, input logic [W-1:0] data);
        exp_t e;
        e.id = id; e.data = data;
        cmd_q.push_back(e);
    endtask

    task automatic exp_resp(input logic id, input logic [W-1:0] data);
        exp_t e;
        e.id = id; e.data = data;
        resp_q.push_back(e);
    endtask

    // Scoreboard monitor: every handshake pops the oldest expectation and checks routing.
    always @(negedge clk_i) begin
        if (reset_i === 1'b1) begin
            if (io_cmd_v_o && io_cmd_yumi_i) begin
                n_cmd_hs++;
                check("cmd_expected", W'(cmd_q.size() != 0), W'(1));
                if (cmd_q.size() != 0) begin
                    exp_t e;
                    e = cmd_q.pop_front();
                    check("cmd_data", io_cmd_o, e.data);
                    check("cmd_yumi", W'({req1_cmd_yumi_o, req0_cmd_yumi_o}), e.id ? W'(2) : W'(1));
                end
            end
            if (io_resp_v_i && io_resp_ready_o) begin
                check("resp_expected", W'(resp_q.size() != 0), W'(1));
                if (resp_q.size() != 0) begin
                    exp_t r;
                    r = resp_q.pop_front();
                    check("resp_v", W'({req1_resp_v_o, req0_resp_v_o}), r.id ? W'(2) : W'(1));
                    check("resp_data", r.id ? req1_resp_o : req0_resp_o, r.data);
                end
            end
        end
    end

    initial begin
        int hs_start;
        logic [W-1:0] payloads [3];
        payloads[0] = 64'h11; payloads[1] = 64'h22; payloads[2] = 64'h33;

        // Reset: outputs low even with requests and stray responses present.
        idle_inputs();
        reset_i = 0;
        req0_cmd_v_i = 1; io_cmd_yumi_i = 1; io_resp_v_i = 1; req0_resp_ready_i = 1;
        #2;
        check("rst_cmd_v", W'(io_cmd_v_o), W'(0));
        check("rst_yumi0", W'(req0_cmd_yumi_o), W'(0));
        check("rst_resp_ready", W'(io_resp_ready_o), W'(0));
        check("rst_resp_v0", W'(req0_resp_v_o), W'(0));
        idle_inputs();
        step(); step();
        reset_i = 1;
        step();
        #1;
        check("post_rst_cmd_v", W'(io_cmd_v_o), W'(0));
        check("post_rst_resp_ready", W'(io_resp_ready_o), W'(0));

        // Single requester: three req1 commands, then three responses routed to req1 only.
        req1_cmd_v_i = 1; io_cmd_yumi_i = 1;
        for (int i = 0; i < 3; i++) begin
            req1_cmd_i = payloads[i];
            exp_cmd(1'b1, payloads[i]);
            #1;
            check("t1_cmd_v", W'(io_cmd_v_o), W'(1));
            check("t1_cmd_zero_lat", io_cmd_o, payloads[i]);
            step();
        end
        req1_cmd_v_i = 0; io_cmd_yumi_i = 0;
        req0_resp_ready_i = 1; req1_resp_ready_i = 1; io_resp_v_i = 1;
        for (int i = 0; i < 3; i++) begin
            io_resp_i = 64'hA1 + W'(i);
            exp_resp(1'b1, 64'hA1 + W'(i));
            #1;
            check("t1_resp_v0_low", W'(req0_resp_v_o), W'(0));
            step();
        end
        // Stray response with empty FIFO is never accepted.
        io_resp_i = 64'hEE;
        #1;
        check("stray_ready", W'(io_resp_ready_o), W'(0));
        check("stray_v", W'({req1_resp_v_o, req0_resp_v_o}), W'(0));

        // Simultaneous requests from reset: grant order 0,1,0,1.
        do_reset();
        req0_cmd_v_i = 1; req1_cmd_v_i = 1; io_cmd_yumi_i = 1;
        req0_cmd_i = 64'hB0; req1_cmd_i = 64'hC0;
        exp_cmd(1'b0, 64'hB0); exp_cmd(1'b1, 64'hC0);
        exp_cmd(1'b0, 64'hB0); exp_cmd(1'b1, 64'hC0);
        repeat (4) step();
        #1;
        check("t2_full_stop", W'(io_cmd_v_o), W'(0));

        // Lock: req0 held for 5 cycles while req1 waits, then req1 wins.
        do_reset();
        req0_cmd_v_i = 1; req0_cmd_i = 64'hD0;
        req1_cmd_v_i = 1; req1_cmd_i = 64'hE0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_lock_data", io_cmd_o, 64'hD0);
            check("t3_lock_yumi", W'({req1_cmd_yumi_o, req0_cmd_yumi_o}), W'(0));
            step();
        end
        io_cmd_yumi_i = 1;
        exp_cmd(1'b0, 64'hD0);
        step();
        req0_cmd_i = 64'hD1;
        exp_cmd(1'b1, 64'hE0);
        step();
        idle_inputs();

        // Full: four issue, two more stall until one response frees a slot.
        do_reset();
        hs_start = n_cmd_hs;
        req0_cmd_v_i = 1; io_cmd_yumi_i = 1;
        for (int i = 0; i < 4; i++) begin
            req0_cmd_i = 64'hF0 + W'(i);
            exp_cmd(1'b0, 64'hF0 + W'(i));
            step();
        end
        req0_cmd_i = 64'hF4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_full_cmd_v", W'(io_cmd_v_o), W'(0));
            step();
        end
        io_resp_v_i = 1; io_resp_i = 64'h55; req0_resp_ready_i = 1;
        exp_resp(1'b0, 64'h55);
        #1;
        check("t4_pop_cycle_cmd_v", W'(io_cmd_v_o), W'(0));
        step();
        io_resp_v_i = 0;
        exp_cmd(1'b0, 64'hF4);
        #1;
        check("t4_freed_cmd_v", W'(io_cmd_v_o), W'(1));
        step();
        req0_cmd_i = 64'hF5;
        #1;
        check("t4_refull_cmd_v", W'(io_cmd_v_o), W'(0));
        check("t4_issue_count", W'(n_cmd_hs - hs_start), W'(5));
        idle_inputs();

        // Response backpressure: head is req0, not ready for 3 cycles.
        do_reset();
        io_cmd_yumi_i = 1;
        req0_cmd_v_i = 1; req0_cmd_i = 64'h01;
        exp_cmd(1'b0, 64'h01);
        step();
        req0_cmd_v_i = 0; req1_cmd_v_i = 1; req1_cmd_i = 64'h02;
        exp_cmd(1'b1, 64'h02);
        step();
        req1_cmd_v_i = 0; io_cmd_yumi_i = 0;
        io_resp_v_i = 1; io_resp_i = 64'h71; req1_resp_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_stall_ready", W'(io_resp_ready_o), W'(0));
            check("t5_stall_v", W'({req1_resp_v_o, req0_resp_v_o}), W'(1));
            step();
        end
        req0_resp_ready_i = 1;
        exp_resp(1'b0, 64'h71);
        step();
        io_resp_i = 64'h72;
        exp_resp(1'b1, 64'h72);
        step();
        idle_inputs();

        // Reset mid-op: three outstanding and locked to req1.
        do_reset();
        io_cmd_yumi_i = 1;
        req0_cmd_v_i = 1; req0_cmd_i = 64'h81; exp_cmd(1'b0, 64'h81); step();
        req0_cmd_v_i = 0; req1_cmd_v_i = 1; req1_cmd_i = 64'h82; exp_cmd(1'b1, 64'h82); step();
        req0_cmd_v_i = 1; req1_cmd_v_i = 0; req0_cmd_i = 64'h83; exp_cmd(1'b0, 64'h83); step();
        req0_cmd_v_i = 0; req1_cmd_v_i = 1; req1_cmd_i = 64'h84; io_cmd_yumi_i = 0;
        step();
        #1;
        check("t6_locked_data", io_cmd_o, 64'h84);
        reset_i = 0;
        req0_resp_ready_i = 1; req1_resp_ready_i = 1; io_resp_v_i = 1; io_resp_i = 64'h90;
        #1;
        check("t6_rst_cmd_v", W'(io_cmd_v_o), W'(0));
        check("t6_rst_resp_ready", W'(io_resp_ready_o), W'(0));
        req1_cmd_v_i = 0;
        step();
        reset_i = 1;
        #1;
        check("t6_stray_ready", W'(io_resp_ready_o), W'(0));
        check("t6_stray_v", W'({req1_resp_v_o, req0_resp_v_o}), W'(0));
        req0_cmd_v_i = 1; req0_cmd_i = 64'h99; io_cmd_yumi_i = 1;
        exp_cmd(1'b0, 64'h99);
        #1;
        check("t6_new_grant", W'({req1_cmd_yumi_o, req0_cmd_yumi_o}), W'(1));
        step();
        idle_inputs();
        step();

        check("cmd_q_drained", W'(cmd_q.size()), W'(0));
        check("resp_q_drained", W'(resp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
